// File: rtl/mcp4812_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mcp4812_rx : oversampled SPI target emulating MCP4812 DAC register behaviour
// Revision   : 1.0
// ----------------------------------------------------------------------------
module mcp4812_rx #(
  parameter int FRAME_BITS = 16,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 CSn,
  input  logic                 SCK,
  input  logic                 SDI,
  input  logic                 LDACn,
  output logic [15:0]          word,
  output logic                 word_valid,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [9:0]           code_a,
  output logic [9:0]           code_b,
  output logic                 gain1x_a,
  output logic                 gain1x_b,
  output logic                 active_a,
  output logic                 active_b
);

  localparam logic [4:0]  C_FRAME_BITS = 5'(FRAME_BITS);
  localparam logic [4:0]  C_CNT_MAX    = 5'd31;
  // Channel registers are packed as {gain1x, active, code}
  localparam logic [11:0] C_REG_RST    = 12'h800;

  logic csn_s1_q, csn_s2_q, csn_h_q;
  logic sck_s1_q, sck_s2_q, sck_h_q;
  logic sdi_s1_q, sdi_s2_q;
  logic ldacn_s1_q, ldacn_s2_q;

  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic [15:0]          shift_q, shift_d;
  logic [15:0]          word_q, word_d;
  logic                 word_valid_q, word_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [11:0]          in_a_q, in_a_d, in_b_q, in_b_d;
  logic [11:0]          out_a_q, out_a_d, out_b_q, out_b_d;

  logic cs_fall, cs_rise, sck_rise;

  always_comb begin
    cs_fall      = ~csn_s2_q & csn_h_q;
    cs_rise      = csn_s2_q & ~csn_h_q;
    sck_rise     = sck_s2_q & ~sck_h_q & ~csn_s2_q;

    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    err_cnt_d    = err_cnt_q;
    in_a_d       = in_a_q;
    in_b_d       = in_b_q;
    out_a_d      = out_a_q;
    out_b_d      = out_b_q;

    if (cs_fall) begin
      bit_cnt_d = 5'd0;
      shift_d   = 16'h0000;
    end else if (sck_rise) begin
      shift_d = {shift_q[14:0], sdi_s2_q};
      if (bit_cnt_q != C_CNT_MAX) begin
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
    end

    if (cs_rise) begin
      if (bit_cnt_q == C_FRAME_BITS) begin
        word_d       = shift_q;
        word_valid_d = 1'b1;
        if (shift_q[15]) begin
          in_b_d = shift_q[13:2];
        end else begin
          in_a_d = shift_q[13:2];
        end
      end else begin
        frame_err_d = 1'b1;
        if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
          err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
      end
    end

    // Outputs take the pre-load input registers, so a same-cycle load lands one cycle later
    if (!ldacn_s2_q) begin
      out_a_d = in_a_q;
      out_b_d = in_b_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csn_s1_q     <= 1'b1;
      csn_s2_q     <= 1'b1;
      csn_h_q      <= 1'b1;
      sck_s1_q     <= 1'b0;
      sck_s2_q     <= 1'b0;
      sck_h_q      <= 1'b0;
      sdi_s1_q     <= 1'b0;
      sdi_s2_q     <= 1'b0;
      ldacn_s1_q   <= 1'b1;
      ldacn_s2_q   <= 1'b1;
      bit_cnt_q    <= 5'd0;
      shift_q      <= 16'h0000;
      word_q       <= 16'h0000;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_cnt_q    <= '0;
      in_a_q       <= C_REG_RST;
      in_b_q       <= C_REG_RST;
      out_a_q      <= C_REG_RST;
      out_b_q      <= C_REG_RST;
    end else begin
      csn_s1_q     <= CSn;
      csn_s2_q     <= csn_s1_q;
      csn_h_q      <= csn_s2_q;
      sck_s1_q     <= SCK;
      sck_s2_q     <= sck_s1_q;
      sck_h_q      <= sck_s2_q;
      sdi_s1_q     <= SDI;
      sdi_s2_q     <= sdi_s1_q;
      ldacn_s1_q   <= LDACn;
      ldacn_s2_q   <= ldacn_s1_q;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      frame_err_q  <= frame_err_d;
      err_cnt_q    <= err_cnt_d;
      in_a_q       <= in_a_d;
      in_b_q       <= in_b_d;
      out_a_q      <= out_a_d;
      out_b_q      <= out_b_d;
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign frame_err  = frame_err_q;
  assign err_cnt    = err_cnt_q;
  assign code_a     = out_a_q[9:0];
  assign active_a   = out_a_q[10];
  assign gain1x_a   = out_a_q[11];
  assign code_b     = out_b_q[9:0];
  assign active_b   = out_b_q[10];
  assign gain1x_b   = out_b_q[11];

endmodule
`default_nettype wire

// File: tb/tb_mcp4812_rx.sv
`default_nettype none
// Bench for mcp4812_rx: frame-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized frames.
module tb_mcp4812_rx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic CSn = 1'b1, SCK = 1'b0, SDI = 1'b0, LDACn = 1'b1;
  logic [15:0] word;
  logic word_valid, frame_err;
  logic [7:0] err_cnt;
  logic [9:0] code_a, code_b;
  logic gain1x_a, gain1x_b, active_a, active_b;

  int total = 0;
  int bad = 0;
  int nwv = 0;
  int nfe = 0;

  mcp4812_rx #(.FRAME_BITS(16), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .CSn(CSn), .SCK(SCK), .SDI(SDI), .LDACn(LDACn),
    .word(word), .word_valid(word_valid), .frame_err(frame_err), .err_cnt(err_cnt),
    .code_a(code_a), .code_b(code_b), .gain1x_a(gain1x_a), .gain1x_b(gain1x_b),
    .active_a(active_a), .active_b(active_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Pin samples at the last four clock edges, index 0 newest.
  logic pc[4], ps[4], pd[4], pl[4];
  int   m_cnt, m_acc;
  int   m_word, m_errc;
  bit   m_wv, m_fe;
  int   ia_code, ib_code, oa_code, ob_code;
  bit   ia_ga, ib_ga, oa_ga, ob_ga, ia_sh, ib_sh, oa_sh, ob_sh;

  task automatic model_reset();
    m_cnt = 0; m_acc = 0; m_word = 0; m_errc = 0; m_wv = 0; m_fe = 0;
    ia_code = 0; ib_code = 0; oa_code = 0; ob_code = 0;
    ia_ga = 1; ib_ga = 1; oa_ga = 1; ob_ga = 1;
    ia_sh = 0; ib_sh = 0; oa_sh = 0; ob_sh = 0;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      pc[k] = 1; ps[k] = 0; pd[k] = 0; pl[k] = 1;
    end
    model_reset();
    forever begin
      @(posedge clk);
      for (int k = 3; k > 0; k--) begin
        pc[k] = pc[k-1]; ps[k] = ps[k-1]; pd[k] = pd[k-1]; pl[k] = pl[k-1];
      end
      if (reset) begin
        pc[0] = 1; ps[0] = 0; pd[0] = 0; pl[0] = 1;
        model_reset();
      end else begin
        pc[0] = CSn; ps[0] = SCK; pd[0] = SDI; pl[0] = LDACn;
        // Decisions are taken on what the pins looked like two and three edges ago
        m_wv = 0; m_fe = 0;
        if (!pl[2]) begin
          oa_code = ia_code; oa_ga = ia_ga; oa_sh = ia_sh;
          ob_code = ib_code; ob_ga = ib_ga; ob_sh = ib_sh;
        end
        if (pc[3] && !pc[2]) begin
          m_cnt = 0; m_acc = 0;
        end else if (!ps[3] && ps[2] && !pc[2]) begin
          m_acc = ((m_acc << 1) | int'(pd[2])) & 32'hFFFF;
          m_cnt++;
        end
        if (!pc[3] && pc[2]) begin
          if (m_cnt == 16) begin
            m_word = m_acc; m_wv = 1;
            if (m_acc >= 32'h8000) begin
              ib_code = (m_acc >> 2) & 32'h3FF; ib_ga = m_acc[13]; ib_sh = m_acc[12];
            end else begin
              ia_code = (m_acc >> 2) & 32'h3FF; ia_ga = m_acc[13]; ia_sh = m_acc[12];
            end
          end else begin
            m_fe = 1;
            if (m_errc < 255) m_errc++;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (word_valid === 1'b1) nwv++;
      if (frame_err === 1'b1) nfe++;
      if (reset) begin
        chk("rst_word", 32'(word), 32'h0);
        chk("rst_flags", {30'd0, word_valid, frame_err}, 32'h0);
        chk("rst_err_cnt", 32'(err_cnt), 32'h0);
        chk("rst_chan_a", {20'd0, gain1x_a, active_a, code_a}, 32'h800);
        chk("rst_chan_b", {20'd0, gain1x_b, active_b, code_b}, 32'h800);
      end else begin
        chk("word", 32'(word), 32'(m_word) & 32'hFFFF);
        chk("word_valid", 32'(word_valid), 32'(m_wv));
        chk("frame_err", 32'(frame_err), 32'(m_fe));
        chk("err_cnt", 32'(err_cnt), 32'(m_errc));
        chk("code_a", 32'(code_a), 32'(oa_code));
        chk("gain_act_a", {30'd0, gain1x_a, active_a}, {30'd0, oa_ga, oa_sh});
        chk("code_b", 32'(code_b), 32'(ob_code));
        chk("gain_act_b", {30'd0, gain1x_b, active_b}, {30'd0, ob_ga, ob_sh});
        chk("wv_fe_exclusive", 32'(word_valid & frame_err), 32'h0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clk_bits(input logic [31:0] data, input int n, input int half);
    for (int i = 0; i < n; i++) begin
      SDI = data[n-1-i];
      cyc(half);
      SCK = 1'b1;
      cyc(half);
      SCK = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] data, input int n, input int half);
    CSn = 1'b0;
    cyc(half);
    clk_bits(data, n, half);
    cyc(half);
    CSn = 1'b1;
    cyc(half);
  endtask

  int wv0;

  initial begin
    cyc(4);
    reset = 1'b0;
    cyc(4);

    // Channel A full-scale, then an LDAC pulse
    wv0 = nwv;
    send_frame(32'h3FFC, 16, 11);
    cyc(5);
    chk("t1_wv_count", 32'(nwv - wv0), 32'd1);
    chk("t1_word", 32'(word), 32'h3FFC);
    chk("t1_code_a_pre_ldac", 32'(code_a), 32'h0);
    LDACn = 1'b0;
    cyc(4);
    LDACn = 1'b1;
    cyc(6);
    chk("t1_code_a", 32'(code_a), 32'h3FF);
    chk("t1_ga_sh_a", {30'd0, gain1x_a, active_a}, 32'h3);
    chk("t1_chan_b", {20'd0, gain1x_b, active_b, code_b}, 32'h800);

    // Channel B with LDAC held high, then released
    send_frame(32'h9554, 16, 5);
    cyc(5);
    chk("t2_code_b_held", 32'(code_b), 32'h0);
    LDACn = 1'b0;
    cyc(5);
    LDACn = 1'b1;
    cyc(4);
    chk("t2_code_b", 32'(code_b), 32'h155);
    chk("t2_ga_sh_b", {30'd0, gain1x_b, active_b}, 32'h1);

    // Wrong-length frames and counter saturation
    wv0 = nwv;
    send_frame(32'h1234, 15, 4);
    send_frame(32'h1ABCD, 17, 4);
    cyc(4);
    chk("t3_err_cnt2", 32'(err_cnt), 32'd2);
    chk("t3_no_wv", 32'(nwv - wv0), 32'd0);
    chk("t3_code_a_kept", 32'(code_a), 32'h3FF);
    for (int i = 0; i < 256; i++) send_frame(32'h1, 1, 3);
    cyc(4);
    chk("t3_err_sat", 32'(err_cnt), 32'hFF);

    // Back-to-back with LDAC held low
    LDACn = 1'b0;
    send_frame(32'h0400, 16, 4);
    send_frame(32'h1800 | 32'h8000, 16, 4);
    cyc(6);
    LDACn = 1'b1;
    chk("t4_code_a", 32'(code_a), 32'h100);
    chk("t4_active_a", 32'(active_a), 32'h0);
    chk("t4_code_b", 32'(code_b), 32'h200);
    chk("t4_active_b", 32'(active_b), 32'h1);

    // Reset in the middle of a frame, release with CSn low
    CSn = 1'b0;
    cyc(4);
    clk_bits(32'hA5, 8, 4);
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(4);
    clk_bits(32'h5A, 8, 4);
    cyc(4);
    CSn = 1'b1;
    cyc(6);
    chk("t5_err_cnt", 32'(err_cnt), 32'd1);

    // SCK with CSn high is ignored; empty frame is an error
    wv0 = nwv;
    for (int i = 0; i < 16; i++) begin
      SCK = 1'b1; cyc(3); SCK = 1'b0; cyc(3);
    end
    CSn = 1'b0;
    cyc(5);
    CSn = 1'b1;
    cyc(6);
    chk("t6_err_cnt", 32'(err_cnt), 32'd2);
    chk("t6_no_wv", 32'(nwv - wv0), 32'd0);

    // Randomized frames, lengths and LDAC activity
    for (int i = 0; i < 60; i++) begin
      int len;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 16;
      LDACn = 1'($urandom_range(0, 1));
      send_frame(32'($urandom), len, int'($urandom_range(3, 8)));
      cyc(int'($urandom_range(0, 6)));
    end
    LDACn = 1'b0;
    cyc(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
